cb_rr: RTL and testbench

- Parametrised N-port crossbar switch with a built-in round-robin switch allocator and wormhole output locking.
- Sits between the input channels and output channels of the router.
- Input ports request an output port; the allocator grants one owner per output and holds it for the whole packet.
- The datapath forwards the owner's flit through one register stage.

---
 rtl/cb_rr.sv | 142 ++++++++++++++
 tb/tb_cb_rr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_rr.sv
`default_nettype none
// ============================================================================
// Module  : cb_rr
// Desc    : NPORT crossbar with per-output round-robin allocator, wormhole
//           output locking and a one-stage registered datapath.
//           Optional macro XBAR_PERF_EN adds per-output saturating flit counters.
// Rev     : 1.0  initial release
// ============================================================================
module cb_rr #(
  parameter int NPORT = 5,
  parameter int DATAW = 32,
  parameter int VCHW  = 1,
  parameter int PORTW = 3
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  input  logic [NPORT*PORTW-1:0] port,
  input  logic [NPORT-1:0]       req,
  output logic [NPORT*NPORT-1:0] grt,
  output logic [NPORT*DATAW-1:0] odata,
  output logic [NPORT-1:0]       ovalid,
  output logic [NPORT*VCHW-1:0]  ovch
`ifdef XBAR_PERF_EN
  ,
  output logic [NPORT*16-1:0]    flit_cnt
`endif
);

  logic [NPORT-1:0] r_owned;
  logic [PORTW-1:0] r_owner [NPORT];
  logic [PORTW-1:0] r_ptr   [NPORT];
  logic [DATAW-1:0] r_odata [NPORT];
  logic [VCHW-1:0]  r_ovch  [NPORT];
  logic [NPORT-1:0] r_ovalid;

  logic [NPORT-1:0] w_req [NPORT];
  logic [NPORT-1:0] w_hold;
  logic [NPORT-1:0] w_found;
  logic [NPORT-1:0] w_sel_valid;
  logic [PORTW-1:0] w_win      [NPORT];
  logic [PORTW-1:0] w_nxt_ptr  [NPORT];
  logic [DATAW-1:0] w_sel_data [NPORT];
  logic [VCHW-1:0]  w_sel_vch  [NPORT];

  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      w_req[j]       = '0;
      w_hold[j]      = 1'b0;
      w_found[j]     = 1'b0;
      w_win[j]       = '0;
      w_nxt_ptr[j]   = r_ptr[j];
      w_sel_valid[j] = 1'b0;
      w_sel_data[j]  = '0;
      w_sel_vch[j]   = '0;
      // Out-of-range port values never match any j, so they never request.
      for (int i = 0; i < NPORT; i++) begin
        w_req[j][i] = req[i] && (port[i*PORTW +: PORTW] == PORTW'(j));
      end
      for (int i = 0; i < NPORT; i++) begin
        if (r_owner[j] == PORTW'(i)) begin
          w_hold[j]      = r_owned[j] && w_req[j][i];
          w_sel_valid[j] = ivalid[i];
          w_sel_data[j]  = idata[i*DATAW +: DATAW];
          w_sel_vch[j]   = ivch[i*VCHW +: VCHW];
        end
      end
      // Rotating scan starting at ptr, wrapping modulo NPORT.
      for (int k = 0; k < NPORT; k++) begin
        if (!w_found[j] && w_req[j][(int'(r_ptr[j]) + k) % NPORT]) begin
          w_found[j] = 1'b1;
          w_win[j]   = PORTW'((int'(r_ptr[j]) + k) % NPORT);
        end
      end
      w_nxt_ptr[j] = PORTW'((int'(w_win[j]) + 1) % NPORT);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_owned  <= '0;
      r_ovalid <= '0;
      for (int j = 0; j < NPORT; j++) begin
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
        r_odata[j] <= '0;
        r_ovch[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        // Datapath uses pre-edge ownership: forward only while grt is high.
        r_ovalid[j] <= r_owned[j] && w_sel_valid[j];
        if (r_owned[j]) begin
          r_odata[j] <= w_sel_data[j];
          r_ovch[j]  <= w_sel_vch[j];
        end
        if (!w_hold[j]) begin
          if (w_found[j]) begin
            r_owned[j] <= 1'b1;
            r_owner[j] <= w_win[j];
            r_ptr[j]   <= w_nxt_ptr[j];
          end else begin
            r_owned[j] <= 1'b0;
          end
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gj = 0; gj < NPORT; gj++) begin : g_out
      assign odata[gj*DATAW +: DATAW] = r_odata[gj];
      assign ovch[gj*VCHW +: VCHW]    = r_ovch[gj];
      assign ovalid[gj]               = r_ovalid[gj];
      for (gi = 0; gi < NPORT; gi++) begin : g_grt
        assign grt[gi*NPORT + gj] = r_owned[gj] && (r_owner[gj] == PORTW'(gi));
      end
    end
  endgenerate

`ifdef XBAR_PERF_EN
  logic [15:0] r_flit_cnt [NPORT];

  generate
    for (gj = 0; gj < NPORT; gj++) begin : g_perf
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          r_flit_cnt[gj] <= '0;
        end else if (r_ovalid[gj] && (r_flit_cnt[gj] != 16'hFFFF)) begin
          r_flit_cnt[gj] <= r_flit_cnt[gj] + 16'd1;
        end
      end
      assign flit_cnt[gj*16 +: 16] = r_flit_cnt[gj];
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_rr.sv
`default_nettype none
// Testbench for cb_rr: directed scenarios plus randomized packet traffic,
// checked each cycle against a behavioural allocator/datapath model.
module tb_cb_rr;
  localparam int NPORT = 5;
  localparam int DATAW = 32;
  localparam int VCHW  = 1;
  localparam int PORTW = 3;

  logic                   clk = 1'b0;
  logic                   rst_ = 1'b0;
  logic [NPORT*DATAW-1:0] idata = '0;
  logic [NPORT-1:0]       ivalid = '0;
  logic [NPORT*VCHW-1:0]  ivch = '0;
  logic [NPORT*PORTW-1:0] port = '0;
  logic [NPORT-1:0]       req = '0;
  logic [NPORT*NPORT-1:0] grt;
  logic [NPORT*DATAW-1:0] odata;
  logic [NPORT-1:0]       ovalid;
  logic [NPORT*VCHW-1:0]  ovch;
`ifdef XBAR_PERF_EN
  logic [NPORT*16-1:0]    flit_cnt;
`endif

  cb_rr #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .port(port), .req(req), .grt(grt), .odata(odata), .ovalid(ovalid),
    .ovch(ovch)
`ifdef XBAR_PERF_EN
    , .flit_cnt(flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per-output ownership, pointer and output registers.
  int             m_owned [NPORT];
  int             m_owner [NPORT];
  int             m_ptr   [NPORT];
  logic           m_ovalid[NPORT];
  logic [DATAW-1:0] m_odata[NPORT];
  logic [VCHW-1:0]  m_ovch [NPORT];
  int             m_cnt   [NPORT];

  function automatic bit wants(int i, int j);
    int p;
    p = int'(port[i*PORTW +: PORTW]);
    return req[i] && (p == j);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NPORT; j++) begin
      m_owned[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
      m_ovalid[j] = 1'b0; m_odata[j] = '0; m_ovch[j] = '0; m_cnt[j] = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    for (int j = 0; j < NPORT; j++) begin
      if (m_ovalid[j] && m_cnt[j] < 65535) m_cnt[j]++;
      m_ovalid[j] = (m_owned[j] != 0) && ivalid[m_owner[j]];
      if (m_owned[j] != 0) begin
        m_odata[j] = idata[m_owner[j]*DATAW +: DATAW];
        m_ovch[j]  = ivch[m_owner[j]*VCHW +: VCHW];
      end
      if (!((m_owned[j] != 0) && wants(m_owner[j], j))) begin
        w = -1;
        for (int k = 0; k < NPORT; k++)
          if (w < 0 && wants((m_ptr[j] + k) % NPORT, j)) w = (m_ptr[j] + k) % NPORT;
        if (w >= 0) begin
          m_owned[j] = 1; m_owner[j] = w; m_ptr[j] = (w + 1) % NPORT;
        end else begin
          m_owned[j] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NPORT*NPORT-1:0] eg;
    logic [NPORT*DATAW-1:0] ed;
    logic [NPORT-1:0]       ev;
    logic [NPORT*VCHW-1:0]  ec;
    eg = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (m_owned[j] != 0) eg[m_owner[j]*NPORT + j] = 1'b1;
      ed[j*DATAW +: DATAW] = m_odata[j];
      ev[j] = m_ovalid[j];
      ec[j*VCHW +: VCHW] = m_ovch[j];
    end
    check("grt", 256'(grt), 256'(eg));
    check("ovalid", 256'(ovalid), 256'(ev));
    check("odata", 256'(odata), 256'(ed));
    check("ovch", 256'(ovch), 256'(ec));
`ifdef XBAR_PERF_EN
    for (int j = 0; j < NPORT; j++)
      check("flit_cnt", 256'(flit_cnt[j*16 +: 16]), 256'(m_cnt[j]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    req = '0; ivalid = '0; idata = '0; ivch = '0; port = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_ = 1'b1;
  endtask

  task automatic set_in(int i, bit r, int p, bit v, logic [DATAW-1:0] d, logic [VCHW-1:0] c);
    req[i] = r;
    port[i*PORTW +: PORTW] = PORTW'(p);
    ivalid[i] = v;
    idata[i*DATAW +: DATAW] = d;
    ivch[i*VCHW +: VCHW] = c;
  endtask

  function automatic int dut_owner(int j);
    int o;
    o = -1;
    for (int i = 0; i < NPORT; i++) if (grt[i*NPORT + j]) o = i;
    return o;
  endfunction

  initial begin
    int seq[$];
    int gcnt[NPORT];
    int rem[NPORT];
    int age[NPORT];
    int cur, prev, rereq;

    // Single path
    do_reset();
    set_in(1, 1'b1, 3, 1'b1, 32'hA5A5_0001, 1'b1);
    step();
    check("single_grt", 256'(grt[1*NPORT + 3]), 256'(1));
    step();
    check("single_odata", 256'(odata[3*DATAW +: DATAW]), 256'(32'hA5A5_0001));
    check("single_ovalid", 256'(ovalid[3]), 256'(1));
    check("single_ovch", 256'(ovch[3*VCHW +: VCHW]), 256'(1));
    req[1] = 1'b0;
    repeat (3) step();

    // Contention / back-to-back handoff on output 1
    do_reset();
    foreach (gcnt[i]) gcnt[i] = 0;
    set_in(0, 1'b1, 1, 1'b1, 32'h1000_0000, 1'b0);
    set_in(2, 1'b1, 1, 1'b1, 32'h2000_0000, 1'b1);
    set_in(4, 1'b1, 1, 1'b1, 32'h4000_0000, 1'b0);
    prev = -1; rereq = -1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c >= 1) check("handoff_nogap", 256'(ovalid[1]), 256'(1));
      for (int i = 0; i < NPORT; i++) idata[i*DATAW +: DATAW] = $urandom;
      if (rereq >= 0) begin req[rereq] = 1'b1; rereq = -1; end
      cur = dut_owner(1);
      if (cur >= 0) begin
        if (cur != prev) begin seq.push_back(cur); gcnt[cur] = 0; end
        prev = cur;
        gcnt[cur]++;
        if (gcnt[cur] == 3) begin req[cur] = 1'b0; rereq = cur; end
      end
    end
    check("rr_count", 256'(seq.size() >= 4), 256'(1));
    if (seq.size() >= 4) begin
      check("rr_owner0", 256'(seq[0]), 256'(0));
      check("rr_owner1", 256'(seq[1]), 256'(2));
      check("rr_owner2", 256'(seq[2]), 256'(4));
      check("rr_owner3", 256'(seq[3]), 256'(0));
    end

    // Illegal port
    do_reset();
    set_in(3, 1'b1, 6, 1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (4) step();
    check("illegal_grt", 256'(grt), 256'(0));
    check("illegal_ovalid", 256'(ovalid), 256'(0));
    req = '0;

    // Reset mid-packet, then re-arbitration from ptr 0
    do_reset();
    set_in(1, 1'b1, 4, 1'b1, 32'h1111_0001, 1'b1);
    set_in(3, 1'b1, 4, 1'b1, 32'h3333_0003, 1'b0);
    step();
    step();
    idata[1*DATAW +: DATAW] = 32'h1111_0002;
    step();
    #2 rst_ = 1'b0;
    #1;
    model_reset();
    check("rst_grt", 256'(grt), 256'(0));
    check("rst_ovalid", 256'(ovalid), 256'(0));
    check("rst_odata", 256'(odata), 256'(0));
    @(posedge clk);
    #1 rst_ = 1'b1;
    step();
    check("rst_rearb", 256'(grt[1*NPORT + 4]), 256'(1));
    step();

    // Randomized packet traffic
    do_reset();
    foreach (rem[i]) begin rem[i] = 0; age[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < NPORT; i++) begin
        idata[i*DATAW +: DATAW] = $urandom;
        ivch[i*VCHW +: VCHW] = VCHW'($urandom);
        ivalid[i] = ($urandom_range(0, 3) != 0);
        if (req[i]) begin
          age[i]++;
          if (m_owned[int'(port[i*PORTW +: PORTW]) % NPORT] != 0 &&
              m_owner[int'(port[i*PORTW +: PORTW]) % NPORT] == i &&
              int'(port[i*PORTW +: PORTW]) < NPORT)
            rem[i]--;
          if (rem[i] <= 0 || age[i] > 40) req[i] = 1'b0;
          else if ($urandom_range(0, 31) == 0)
            port[i*PORTW +: PORTW] = PORTW'($urandom_range(0, 7));
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          port[i*PORTW +: PORTW] = PORTW'($urandom_range(0, 7));
          rem[i] = $urandom_range(1, 4);
          age[i] = 0;
        end
      end
    end

`ifdef XBAR_PERF_EN
    do_reset();
    set_in(0, 1'b1, 2, 1'b1, 32'h0, 1'b0);
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check("perf_sat", 256'(flit_cnt[2*16 +: 16]), 256'(16'hFFFF));
    check("perf_other", 256'({flit_cnt[4*16 +: 32], flit_cnt[0 +: 32]}), 256'(0));
    check_all();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
